// File: rtl/deb_scan_pkg.sv
// Shared types, default constants and the round-robin pick helper for the debounce scan controller.
package deb_scan_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_SCAN} deb_state_e;

  localparam int DEB_TICK_DIV_DEF = 10000;
  localparam int DEB_CNT_W_DEF    = 5;

  // Channel-index width. Clamped to 1 so that a single-channel build still has a legal vector.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of pend at or after ptr, wrapping at n; returns ptr when nothing is set.
  function automatic logic [4:0] rr_pick(input logic [31:0] pend, input logic [4:0] ptr,
                                         input int n);
    logic [4:0] pick;
    logic       found;
    int         c;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        c = int'(ptr) + i;
        if (c >= n) c = c - n;
        if (!found && pend[c[4:0]]) begin
          pick  = c[4:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/deb_scan_ctrl_if.sv
// Event handshake bundle between the debounce controller (master) and the register/IRQ logic (slave).
interface deb_scan_ctrl_if #(parameter int N_CH = 8);
  import deb_scan_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;
  logic            evt_ready;

  modport master (output evt_valid, output evt_ch, output evt_level, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_level, output evt_ready);
endinterface

// File: rtl/deb_rr_arb.sv
// Pending-flag store and round-robin event presenter; a new accept on a channel beats its clear.
module deb_rr_arb
  import deb_scan_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            ena,
  input  logic [N_CH-1:0] set_pend,
  input  logic [N_CH-1:0] filt,
  deb_scan_ctrl_if.master evt
);

  localparam int CH_W = ch_width(N_CH);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] pend_n;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] pick;
  logic            hs;

  assign hs   = evt.evt_valid && evt.evt_ready;
  assign pick = CH_W'(rr_pick(32'(pend), 5'(rr_ptr), N_CH));

  always_comb begin
    pend_n = pend;
    if (hs) pend_n[evt.evt_ch] = 1'b0;
    pend_n = pend_n | set_pend;
    if (!ena) pend_n = '0;
  end

  // A presented event stays frozen until accepted, so each handshake costs one idle cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pend          <= '0;
      rr_ptr        <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_ch    <= '0;
      evt.evt_level <= 1'b0;
    end else begin
      pend <= pend_n;
      if (!ena) begin
        evt.evt_valid <= 1'b0;
      end else if (hs) begin
        evt.evt_valid <= 1'b0;
        rr_ptr        <= (evt.evt_ch == CH_W'(N_CH - 1)) ? '0 : evt.evt_ch + CH_W'(1);
      end else if (!evt.evt_valid && (pend != '0)) begin
        evt.evt_valid <= 1'b1;
        evt.evt_ch    <= pick;
        evt.evt_level <= filt[pick];
      end
    end
  end

endmodule

// File: rtl/deb_scan_ctrl.sv
// Time-multiplexed debounce: shared tick prescaler and scan FSM walking per-channel counters.
// Optional DEB_SCAN_SYNC_EN adds a 2-flop input synchronizer in front of all uses of data_in.
module deb_scan_ctrl
  import deb_scan_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int TICK_DIV = DEB_TICK_DIV_DEF,
  parameter int CNT_W    = DEB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ena,
  input  logic [CNT_W-1:0] deb_time,
  input  logic [N_CH-1:0]  data_in,
  output logic [N_CH-1:0]  data_out,
  output logic             busy,
  deb_scan_ctrl_if.master  evt
);

  localparam int CH_W  = ch_width(N_CH);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_CH-1:0]  din;
  logic [N_CH-1:0]  filt;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  set_pend;
  logic [PRE_W-1:0] pre;
  logic             tick;
  deb_state_e       state, state_n;
  logic [CH_W-1:0]  idx, idx_n;
  logic             in_bit, differ, accept;

`ifdef DEB_SCAN_SYNC_EN
  logic [N_CH-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= data_in;
      sync_q2 <= sync_q1;
    end
  end

  assign din = sync_q2;
`else
  assign din = data_in;
`endif

  assign tick = ena && (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res)            pre <= '0;
    else if (!ena || tick) pre <= '0;
    else                pre <= pre + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (!ena) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: if (tick) begin
          state_n = ST_SCAN;
          idx_n   = '0;
        end
        ST_SCAN: if (idx == CH_W'(N_CH - 1)) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + CH_W'(1);
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  assign busy   = (state == ST_SCAN);
  assign in_bit = din[idx];
  assign differ = (in_bit != filt[idx]);
  // >= rather than == so that lowering deb_time mid-count still accepts instead of wrapping.
  assign accept = ena && busy && differ && (cnt[idx] >= deb_time);

  always_comb begin
    set_pend = '0;
    if (accept) set_pend[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      filt <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (!ena) begin
      filt <= din;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (busy) begin
      if (!differ) begin
        cnt[idx] <= '0;
      end else if (accept) begin
        filt[idx] <= in_bit;
        cnt[idx]  <= '0;
      end else begin
        cnt[idx] <= cnt[idx] + CNT_W'(1);
      end
    end
  end

  assign data_out = ena ? filt : din;

  deb_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk      (clk),
    .res      (res),
    .ena      (ena),
    .set_pend (set_pend),
    .filt     (filt),
    .evt      (evt)
  );

endmodule

// File: tb/tb_deb_scan_ctrl.sv
// Directed bench for deb_scan_ctrl with an event scoreboard; honours DEB_SCAN_SYNC_EN input latency.
module tb_deb_scan_ctrl;
  import deb_scan_pkg::*;

  localparam int N_CH     = 4;
  localparam int TICK_DIV = 16;
  localparam int CNT_W    = 5;
`ifdef DEB_SCAN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic [1:0] ch;
    logic       lvl;
  } exp_t;

  logic             clk = 1'b0;
  logic             res;
  logic             ena;
  logic [CNT_W-1:0] deb_time;
  logic [N_CH-1:0]  data_in;
  logic [N_CH-1:0]  data_out;
  logic             busy;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  deb_scan_ctrl_if #(.N_CH(N_CH)) ev();

  deb_scan_ctrl #(.N_CH(N_CH), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .res      (res),
    .ena      (ena),
    .deb_time (deb_time),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .evt      (ev)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the first SCAN cycle of the next scan.
  task automatic wait_scan_start();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin @(negedge clk); n++; end
    while (busy !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check_output("scan_timeout", 32'(n), 32'd0);
  endtask

  // Every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (ev.evt_valid === 1'b1 && ev.evt_ready === 1'b1) begin
      check_output("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("evt_ch", 32'(ev.evt_ch), 32'(e.ch));
        check_output("evt_level", 32'(ev.evt_level), 32'(e.lvl));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    res = 1'b1; ena = 1'b1; deb_time = 5'd2; data_in = '0; ev.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_data_out", 32'(data_out), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_valid", 32'(ev.evt_valid), 32'd0);
    check_output("rst_ch", 32'(ev.evt_ch), 32'd0);
    check_output("rst_level", 32'(ev.evt_level), 32'd0);
    res = 1'b0;

    // Reset mid-scan, then time the first tick after release.
    wait_scan_start();
    @(negedge clk);
    res = 1'b1;
    #1;
    check_output("midscan_busy", 32'(busy), 32'd0);
    check_output("midscan_valid", 32'(ev.evt_valid), 32'd0);
    check_output("midscan_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    res = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < 64);
    check_output("busy_after_rst", 32'(n), 32'(TICK_DIV));
    n = 1;
    while (n < 64) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    check_output("busy_width", 32'(n), 32'(N_CH));

    // Clean edge on channel 1.
    data_in = 4'b0010;
    exp_q.push_back('{ch: 2'd1, lvl: 1'b1});
    repeat (3) wait_scan_start();
    @(negedge clk);
    check_output("edge_before", 32'(data_out), 32'h0);
    @(negedge clk);
    check_output("edge_data_out", 32'(data_out), 32'h2);
    check_output("edge_valid_lat", 32'(ev.evt_valid), 32'd0);
    @(negedge clk);
    check_output("edge_valid", 32'(ev.evt_valid), 32'd1);
    check_output("edge_ch", 32'(ev.evt_ch), 32'd1);
    check_output("edge_level", 32'(ev.evt_level), 32'd1);
    ev.evt_ready = 1'b1;
    @(negedge clk);
    check_output("edge_valid_drop", 32'(ev.evt_valid), 32'd0);
    ev.evt_ready = 1'b0;

    // Bounce: two differing scans then one agreeing scan never qualifies.
    for (int r = 0; r < 3; r++) begin
      data_in[0] = 1'b1;
      wait_scan_start();
      wait_scan_start();
      repeat (5) @(negedge clk);
      data_in[0] = 1'b0;
      wait_scan_start();
      repeat (5) @(negedge clk);
      check_output("bounce_data_out", 32'(data_out), 32'h2);
      check_output("bounce_valid", 32'(ev.evt_valid), 32'd0);
    end

    // Round-robin from rr_ptr=2: ch0, ch2, ch3 two cycles apart.
    ev.evt_ready = 1'b1;
    data_in = 4'b1111;
    exp_q.push_back('{ch: 2'd0, lvl: 1'b1});
    exp_q.push_back('{ch: 2'd2, lvl: 1'b1});
    exp_q.push_back('{ch: 2'd3, lvl: 1'b1});
    repeat (3) wait_scan_start();
    repeat (2) @(negedge clk);
    check_output("rr_v0", 32'(ev.evt_valid), 32'd1);
    check_output("rr_ch0", 32'(ev.evt_ch), 32'd0);
    @(negedge clk);
    check_output("rr_gap0", 32'(ev.evt_valid), 32'd0);
    @(negedge clk);
    check_output("rr_v2", 32'(ev.evt_valid), 32'd1);
    check_output("rr_ch2", 32'(ev.evt_ch), 32'd2);
    @(negedge clk);
    check_output("rr_gap2", 32'(ev.evt_valid), 32'd0);
    ev.evt_ready = 1'b0;
    @(negedge clk);
    check_output("rr_v3", 32'(ev.evt_valid), 32'd1);
    check_output("rr_ch3", 32'(ev.evt_ch), 32'd3);

    // ch0 falls while ch3 is still waiting: ch3 first, then ch0.
    data_in = 4'b1110;
    exp_q.push_back('{ch: 2'd0, lvl: 1'b0});
    repeat (3) wait_scan_start();
    repeat (2) @(negedge clk);
    check_output("hold_valid", 32'(ev.evt_valid), 32'd1);
    check_output("hold_ch3", 32'(ev.evt_ch), 32'd3);
    ev.evt_ready = 1'b1;
    @(negedge clk);
    check_output("after3_gap", 32'(ev.evt_valid), 32'd0);
    @(negedge clk);
    check_output("after3_ch0", 32'(ev.evt_ch), 32'd0);
    check_output("after3_lvl0", 32'(ev.evt_level), 32'd0);
    @(negedge clk);
    check_output("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Collision: ch2 handshake on the same edge as a new ch2 accept.
    ev.evt_ready = 1'b0;
    data_in = 4'b1010;
    exp_q.push_back('{ch: 2'd2, lvl: 1'b0});
    repeat (3) wait_scan_start();
    repeat (5) @(negedge clk);
    check_output("col_first_valid", 32'(ev.evt_valid), 32'd1);
    check_output("col_first_ch", 32'(ev.evt_ch), 32'd2);
    check_output("col_first_lvl", 32'(ev.evt_level), 32'd0);
    data_in = 4'b1110;
    exp_q.push_back('{ch: 2'd2, lvl: 1'b1});
    repeat (3) wait_scan_start();
    check_output("col_held_lvl", 32'(ev.evt_level), 32'd0);
    repeat (2) @(negedge clk);
    ev.evt_ready = 1'b1;
    @(negedge clk);
    check_output("col_gap", 32'(ev.evt_valid), 32'd0);
    @(negedge clk);
    check_output("col_second_valid", 32'(ev.evt_valid), 32'd1);
    check_output("col_second_ch", 32'(ev.evt_ch), 32'd2);
    check_output("col_second_lvl", 32'(ev.evt_level), 32'd1);
    @(negedge clk);
    check_output("col_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("col_data_out", 32'(data_out), 32'hE);

    // Bypass, then re-enable with unchanged inputs.
    ena = 1'b0;
    data_in = 4'b1010;
    repeat (SYNC_LAT) @(negedge clk);
    #1;
    check_output("byp_data_out", 32'(data_out), 32'hA);
    check_output("byp_valid", 32'(ev.evt_valid), 32'd0);
    repeat (20) @(negedge clk);
    check_output("byp_busy", 32'(busy), 32'd0);
    check_output("byp_hold", 32'(data_out), 32'hA);
    ena = 1'b1;
    repeat (5) wait_scan_start();
    repeat (5) @(negedge clk);
    check_output("reen_valid", 32'(ev.evt_valid), 32'd0);
    check_output("reen_data_out", 32'(data_out), 32'hA);
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deb_scan_ctrl.md
# deb_scan_ctrl

Time-multiplexed debounce controller for the board's button and switch inputs. One shared tick prescaler and one scan FSM sequence per-channel debounce counters, so N_CH inputs are filtered without N_CH separate prescalers. Filtered level changes are queued as per-channel pending flags and presented to the register/IRQ logic through a round-robin valid/ready event port.

## Interface
- N_CH, 8: number of debounced channels, 1..32.
- TICK_DIV, 10000: clk cycles per debounce tick (100 us at 100 MHz). Must be ≥ N_CH + 2.
- CNT_W, 5: width of each per-channel tick counter and of deb_time.
- clk in 1: system clock, 100 MHz.
- res in 1: reset. Asynchronous, active-high.
- ena in 1: enable; 0 = bypass, clear counters and pending flags.
- deb_time in CNT_W: debounce time in ticks, minus 1.
- data_in in N_CH: raw inputs.
- data_out out N_CH: filtered levels. When ena=0, equal to data_in (post-sync).
- busy out 1: FSM in SCAN.
- evt_valid out 1: an event is presented.
- evt_ch out $clog2(N_CH): channel of the presented event.
- evt_level out 1: filtered level of evt_ch, sampled at presentation.
- evt_ready in 1: consumer accepts the event.

## Operation
- Prescaler: `pre` counts 0..TICK_DIV-1 while ena=1. `tick` is asserted for one cycle when pre==TICK_DIV-1, and pre wraps to 0. With ena=0, pre is held at 0.
- FSM states: IDLE, SCAN.
  - IDLE→SCAN on tick, with idx=0.
  - SCAN processes channel idx each cycle, then idx+1.
  - SCAN→IDLE after idx==N_CH-1.
  - ena=0 forces IDLE and idx=0 in the next cycle.
- Per-channel processing of idx, with `in` = data_in[idx] and `f` = filt[idx]:
  - If in==f: cnt[idx]←0.
  - Else if cnt[idx] ≥ deb_time: filt[idx]←in, cnt[idx]←0, pend[idx]←1.
  - Else: cnt[idx]←cnt[idx]+1.
  - The ≥ compare keeps a mid-count reduction of deb_time safe. cnt never wraps.
- Net effect: a level must differ on deb_time+1 consecutive scans before it is accepted. deb_time=0 accepts on the first differing scan.
- ena=0:
  - filt←data_in every cycle; all cnt←0; all pend←0; evt_valid←0.
  - data_out=data_in combinationally.
  - Re-enabling produces no spurious event.
- Event port:
  - When evt_valid=0 and pend≠0, the next cycle loads evt_ch = first set pend bit at or after rr_ptr (wrapping), evt_level = filt[evt_ch], and evt_valid=1.
  - evt_ch and evt_level hold stable until handshake (evt_valid & evt_ready).
  - On handshake: pend[evt_ch]←0, rr_ptr←evt_ch+1 (wrapping at N_CH), evt_valid←0 in the next cycle.
  - Maximum throughput: one event per 2 cycles.
- Simultaneous set and clear of pend on the same channel in one cycle: set wins. The newer edge is reported again.
- Multiple edges on one channel before acknowledgement collapse into one pending flag. evt_level reflects the level at load time.

## Timing
- Reset values: data_out=0, busy=0, evt_valid=0, evt_ch=0, evt_level=0. Internal state: filt=0, cnt=0, pend=0, pre=0, idx=0, rr_ptr=0, state=IDLE.
- Scan: busy rises the cycle after tick and stays high for N_CH cycles.
- Channel k is updated in cycle tick+1+k. filt and data_out change at the edge ending that cycle.
- pend→evt_valid latency: 1 cycle.
- evt_ready is ignored while evt_valid=0.
- res asserted mid-scan or mid-handshake returns every register to its reset value immediately, with no event emitted.

## Configuration
- DEB_SCAN_SYNC_EN
  - Defined: data_in passes through a 2-flop synchronizer, reset to 0, before all use, including the ena=0 bypass. This adds 2 cycles of input latency.
  - Undefined: data_in is used directly. Inputs are assumed already synchronous to clk.

## Structure
- Package deb_scan_pkg holds:
  - State enum: ST_IDLE, ST_SCAN.
  - Default constants: DEB_TICK_DIV_DEF=10000, DEB_CNT_W_DEF=5.
  - Function rr_pick(pend, ptr) returning the next channel index.
- Sub-module deb_rr_arb: round-robin pending-flag arbiter and event output register, covering pend set/clear, rr_ptr, and the evt_* handshake. The scan FSM, prescaler and counters stay in deb_scan_ctrl.

## Test plan
- Reset and hold (TICK_DIV=16, N_CH=4, deb_time=2, ena=1): assert res mid-scan → all outputs 0 in the same cycle. busy stays low until the first tick after release.
- Clean edge: data_in[1] 0→1 and held → data_out[1]=1 after the 3rd scan of channel 1 (cycle tick3+2). evt_valid=1 one cycle later with evt_ch=1, evt_level=1. Assert evt_ready → evt_valid=0 in the next cycle.
- Bounce rejection: data_in[0] toggles 1 for 2 ticks, then 0 for 1 tick, repeated, with deb_time=2 → data_out[0] stays 0 and no event is issued.
- Round-robin: channels 0, 2 and 3 flip in the same scan, with evt_ready held 1 → events ch0, ch2, ch3 in that order, spaced 2 cycles apart. A subsequent flip on ch0 while ch3 is pending is reported after ch3.
- Set/clear collision: the handshake of ch2 coincides with a new accepted edge on ch2 → pend[2] remains 1, and a second ch2 event follows with the new level.
- Bypass: ena=0 with data_in=4'b1010 → data_out=4'b1010 immediately (plus 2 cycles if DEB_SCAN_SYNC_EN), no events. Re-enable with unchanged inputs → no event over 5 ticks.
